// File: rtl/tl_tx_fc_pkg.sv
// Shared definitions for the transmit flow-control credit gate.
// Build option: TL_TX_FC_SCALED_EN enables HdrScale/DataScale handling and
// widens the credit counters. When it is not defined, the scale fields are
// ignored and narrower counters are used.
package tl_tx_fc_pkg;

    localparam int unsigned PAYLOAD_LENGTH   = 10;
    localparam int unsigned PAYLOAD_IN_CREDS = 9;
    localparam int unsigned FC_HDR_FIELD_W   = 8;
    localparam int unsigned FC_DATA_FIELD_W  = 12;
    localparam int unsigned FC_SCALE_W       = 2;
    localparam int unsigned FC_SHIFT_W       = 3;

`ifdef TL_TX_FC_SCALED_EN
    localparam int unsigned HDR_CL_W  = 12;
    localparam int unsigned DATA_CL_W = 16;
`else
    localparam int unsigned HDR_CL_W  = 8;
    localparam int unsigned DATA_CL_W = 12;
`endif

    // Credit gate state
    typedef enum logic [1:0] {
        FC_IDLE   = 2'd0,
        FC_INIT   = 2'd1,
        FC_ACTIVE = 2'd2
    } fc_state_e;

    // Flow-control type served by an instance
    typedef enum logic [1:0] {
        FC_TYPE_P   = 2'd0,
        FC_TYPE_NP  = 2'd1,
        FC_TYPE_CPL = 2'd2
    } fc_type_e;

    // Scale field encodings
    localparam logic [FC_SCALE_W-1:0] SCALE_NONE = 2'b00;
    localparam logic [FC_SCALE_W-1:0] SCALE_X1   = 2'b01;
    localparam logic [FC_SCALE_W-1:0] SCALE_X4   = 2'b10;
    localparam logic [FC_SCALE_W-1:0] SCALE_X16  = 2'b11;

    // Left-shift applied to an advertised field for each scale code
    localparam logic [FC_SHIFT_W-1:0] SHIFT_NONE = 3'd0;
    localparam logic [FC_SHIFT_W-1:0] SHIFT_X4   = 3'd2;
    localparam logic [FC_SHIFT_W-1:0] SHIFT_X16  = 3'd4;

    // Map a scale code to its shift amount
    function automatic logic [FC_SHIFT_W-1:0] fc_scale_shift(input logic [FC_SCALE_W-1:0] scale);
        logic [FC_SHIFT_W-1:0] shift;
        case (scale)
            SCALE_X4:  shift = SHIFT_X4;
            SCALE_X16: shift = SHIFT_X16;
            default:   shift = SHIFT_NONE;
        endcase
        return shift;
    endfunction

endpackage

// File: rtl/tl_tx_fc_dw2creds.sv
// Converts a TLP payload length in DW into 4-DW data credits.
// A length field of zero encodes 1024 DW (256 credits); header-only TLPs need none.
module tl_tx_fc_dw2creds
    import tl_tx_fc_pkg::*;
(
    input  logic                        has_data,
    input  logic [PAYLOAD_LENGTH-1:0]   len_dw,
    output logic [PAYLOAD_IN_CREDS-1:0] creds_c
);

    localparam logic [PAYLOAD_IN_CREDS-1:0] MAX_CREDS = PAYLOAD_IN_CREDS'(256);

    logic [PAYLOAD_LENGTH:0] len_rounded;

    // Round the length up to the next multiple of 4 DW
    always_comb begin
        len_rounded = {1'b0, len_dw} + (PAYLOAD_LENGTH + 1)'(3);
        creds_c     = '0;
        if (has_data) begin
            if (len_dw == '0) begin
                creds_c = MAX_CREDS;
            end else begin
                creds_c = PAYLOAD_IN_CREDS'(len_rounded >> 2);
            end
        end
    end

endmodule

// File: rtl/tl_tx_fc_credit_gate.sv
// Transmit flow-control credit gate for one FC type.
// Tracks the partner's advertised header/data credit limits (InitFC/UpdateFC),
// counts credits consumed by granted TLPs and grants a TLP only when both
// header and data credits suffice. Build option: TL_TX_FC_SCALED_EN.
module tl_tx_fc_credit_gate
    import tl_tx_fc_pkg::*;
(
    input  logic                        clk,
    input  logic                        arst_n,
    input  logic                        dl_up,
    input  logic                        fc_init_valid,
    input  logic                        fc_upd_valid,
    input  logic [FC_HDR_FIELD_W-1:0]   fc_hdr,
    input  logic [FC_DATA_FIELD_W-1:0]  fc_data,
    input  logic [FC_SCALE_W-1:0]       fc_hdr_scale,
    input  logic [FC_SCALE_W-1:0]       fc_data_scale,
    input  logic                        req_valid,
    input  logic                        req_has_data,
    input  logic [PAYLOAD_LENGTH-1:0]   req_len_dw,
    output logic                        req_grant,
    output logic                        fc_active,
    output logic [HDR_CL_W-1:0]         hdr_creds_avail,
    output logic [DATA_CL_W-1:0]        data_creds_avail
);

    // Largest legal gap between limit and consumed+required (half the counter range)
    localparam logic [HDR_CL_W-1:0]  HDR_HALF  = {1'b1, {(HDR_CL_W-1){1'b0}}};
    localparam logic [DATA_CL_W-1:0] DATA_HALF = {1'b1, {(DATA_CL_W-1){1'b0}}};
    localparam logic [HDR_CL_W-1:0]  HDR_REQ   = HDR_CL_W'(1);

    fc_state_e              state_q, state_d;
    logic [HDR_CL_W-1:0]    hdr_lim_q, hdr_lim_d;
    logic [DATA_CL_W-1:0]   data_lim_q, data_lim_d;
    logic [HDR_CL_W-1:0]    hdr_cons_q, hdr_cons_d;
    logic [DATA_CL_W-1:0]   data_cons_q, data_cons_d;
    logic                   hdr_inf_q, hdr_inf_d;
    logic                   data_inf_q, data_inf_d;

    logic [FC_SHIFT_W-1:0]       hdr_shift;
    logic [FC_SHIFT_W-1:0]       data_shift;
    logic [HDR_CL_W-1:0]         hdr_lim_load;
    logic [DATA_CL_W-1:0]        data_lim_load;
    logic [PAYLOAD_IN_CREDS-1:0] data_req_c;
    logic [DATA_CL_W-1:0]        data_req_ext;
    logic [HDR_CL_W-1:0]         hdr_gap;
    logic [DATA_CL_W-1:0]        data_gap;
    logic                        hdr_ok;
    logic                        data_ok;

`ifdef TL_TX_FC_SCALED_EN
    // Scale codes select the shift applied to advertised fields
    assign hdr_shift  = fc_scale_shift(fc_hdr_scale);
    assign data_shift = fc_scale_shift(fc_data_scale);
`else
    // Unscaled build: advertised fields are used as-is
    logic unused_scale;
    assign unused_scale = ^{fc_hdr_scale, fc_data_scale};
    assign hdr_shift    = SHIFT_NONE;
    assign data_shift   = SHIFT_NONE;
`endif

    // Limits as they would be loaded from the current DLLP fields
    assign hdr_lim_load  = HDR_CL_W'(fc_hdr) << hdr_shift;
    assign data_lim_load = DATA_CL_W'(fc_data) << data_shift;

    tl_tx_fc_dw2creds u_dw2creds (
        .has_data (req_has_data),
        .len_dw   (req_len_dw),
        .creds_c  (data_req_c)
    );

    assign data_req_ext = DATA_CL_W'(data_req_c);

    // Credit sufficiency: remaining gap after this TLP must not look negative
    always_comb begin
        hdr_gap  = hdr_lim_q - (hdr_cons_q + HDR_REQ);
        data_gap = data_lim_q - (data_cons_q + data_req_ext);
        hdr_ok   = hdr_inf_q || (hdr_gap <= HDR_HALF);
        data_ok  = data_inf_q || (data_req_c == '0) || (data_gap <= DATA_HALF);
    end

    assign fc_active        = (state_q == FC_ACTIVE);
    assign req_grant        = req_valid & fc_active & hdr_ok & data_ok;
    assign hdr_creds_avail  = hdr_inf_q  ? '1 : (hdr_lim_q - hdr_cons_q);
    assign data_creds_avail = data_inf_q ? '1 : (data_lim_q - data_cons_q);

    // FSM next state: link up -> await InitFC -> active; link down always idles
    always_comb begin
        state_d = state_q;
        case (state_q)
            FC_IDLE:   if (dl_up) state_d = FC_INIT;
            FC_INIT:   if (fc_init_valid) state_d = FC_ACTIVE;
            FC_ACTIVE: state_d = FC_ACTIVE;
            default:   state_d = FC_IDLE;
        endcase
        if (!dl_up) begin
            state_d = FC_IDLE;
        end
    end

    // Limit, infinite-flag and consumed-counter next values
    always_comb begin
        hdr_lim_d   = hdr_lim_q;
        data_lim_d  = data_lim_q;
        hdr_cons_d  = hdr_cons_q;
        data_cons_d = data_cons_q;
        hdr_inf_d   = hdr_inf_q;
        data_inf_d  = data_inf_q;

        if ((state_q == FC_INIT) && fc_init_valid) begin
            hdr_lim_d  = hdr_lim_load;
            data_lim_d = data_lim_load;
            hdr_inf_d  = (fc_hdr == '0);
            data_inf_d = (fc_data == '0);
        end else if ((state_q == FC_ACTIVE) && fc_upd_valid) begin
            // Infinite fields keep their limit; only finite ones track updates
            if (!hdr_inf_q) begin
                hdr_lim_d = hdr_lim_load;
            end
            if (!data_inf_q) begin
                data_lim_d = data_lim_load;
            end
        end

        // Consumption uses the pre-edge limit decision and wraps freely
        if (req_grant) begin
            hdr_cons_d  = hdr_cons_q + HDR_REQ;
            data_cons_d = data_cons_q + data_req_ext;
        end

        if (!dl_up) begin
            hdr_lim_d   = '0;
            data_lim_d  = '0;
            hdr_cons_d  = '0;
            data_cons_d = '0;
            hdr_inf_d   = 1'b0;
            data_inf_d  = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= FC_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Credit registers
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            hdr_lim_q   <= '0;
            data_lim_q  <= '0;
            hdr_cons_q  <= '0;
            data_cons_q <= '0;
            hdr_inf_q   <= 1'b0;
            data_inf_q  <= 1'b0;
        end else begin
            hdr_lim_q   <= hdr_lim_d;
            data_lim_q  <= data_lim_d;
            hdr_cons_q  <= hdr_cons_d;
            data_cons_q <= data_cons_d;
            hdr_inf_q   <= hdr_inf_d;
            data_inf_q  <= data_inf_d;
        end
    end

endmodule

// File: tb/tb_tl_tx_fc_credit_gate.sv
// Self-checking bench for tl_tx_fc_credit_gate: directed scenarios followed by
// randomized traffic, all compared against an integer-arithmetic reference model.
module tb_tl_tx_fc_credit_gate;
    import tl_tx_fc_pkg::*;

    localparam int MH = 1 << HDR_CL_W;
    localparam int MD = 1 << DATA_CL_W;
`ifdef TL_TX_FC_SCALED_EN
    localparam bit SCALED = 1'b1;
`else
    localparam bit SCALED = 1'b0;
`endif

    logic                        clk;
    logic                        arst_n;
    logic                        dl_up;
    logic                        fc_init_valid;
    logic                        fc_upd_valid;
    logic [7:0]                  fc_hdr;
    logic [11:0]                 fc_data;
    logic [1:0]                  fc_hdr_scale;
    logic [1:0]                  fc_data_scale;
    logic                        req_valid;
    logic                        req_has_data;
    logic [PAYLOAD_LENGTH-1:0]   req_len_dw;
    logic                        req_grant;
    logic                        fc_active;
    logic [HDR_CL_W-1:0]         hdr_creds_avail;
    logic [DATA_CL_W-1:0]        data_creds_avail;

    tl_tx_fc_credit_gate dut (
        .clk              (clk),
        .arst_n           (arst_n),
        .dl_up            (dl_up),
        .fc_init_valid    (fc_init_valid),
        .fc_upd_valid     (fc_upd_valid),
        .fc_hdr           (fc_hdr),
        .fc_data          (fc_data),
        .fc_hdr_scale     (fc_hdr_scale),
        .fc_data_scale    (fc_data_scale),
        .req_valid        (req_valid),
        .req_has_data     (req_has_data),
        .req_len_dw       (req_len_dw),
        .req_grant        (req_grant),
        .fc_active        (fc_active),
        .hdr_creds_avail  (hdr_creds_avail),
        .data_creds_avail (data_creds_avail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_pass  = 0;
    int    n_total = 0;
    int    n_fail  = 0;
    string phase   = "reset";
    logic  dut_grant_seen;

    // Reference model: link bookkeeping plus integer limits/consumed counts
    bit m_await_init, m_active, m_hinf, m_dinf;
    int m_hlim, m_dlim, m_hcons, m_dcons;

    function automatic int wrapm(input int x, input int m);
        int r;
        r = x % m;
        if (r < 0) r = r + m;
        return r;
    endfunction

    function automatic int m_shift(input int s);
`ifdef TL_TX_FC_SCALED_EN
        if (s == 3) return 4;
        if (s == 2) return 2;
        return 0;
`else
        return s * 0;
`endif
    endfunction

    function automatic int m_data_req();
        if (req_has_data !== 1'b1) return 0;
        if (req_len_dw == '0) return 256;
        return (int'(req_len_dw) + 3) / 4;
    endfunction

    function automatic bit m_grant();
        int  dreq;
        bit  hok;
        bit  dok;
        dreq = m_data_req();
        hok  = m_hinf || (wrapm(m_hlim - (m_hcons + 1), MH) <= MH / 2);
        dok  = m_dinf || (dreq == 0) || (wrapm(m_dlim - (m_dcons + dreq), MD) <= MD / 2);
        return (req_valid === 1'b1) && m_active && hok && dok;
    endfunction

    task automatic model_clear();
        m_await_init = 1'b0; m_active = 1'b0;
        m_hinf = 1'b0; m_dinf = 1'b0;
        m_hlim = 0; m_dlim = 0; m_hcons = 0; m_dcons = 0;
    endtask

    task automatic model_edge(input bit g);
        int dreq;
        dreq = m_data_req();
        if (dl_up !== 1'b1) begin
            model_clear();
        end else if (!m_await_init && !m_active) begin
            m_await_init = 1'b1;
        end else if (m_await_init) begin
            if (fc_init_valid === 1'b1) begin
                m_hlim = wrapm(int'(fc_hdr) << m_shift(int'(fc_hdr_scale)), MH);
                m_dlim = wrapm(int'(fc_data) << m_shift(int'(fc_data_scale)), MD);
                m_hinf = (fc_hdr == 0);
                m_dinf = (fc_data == 0);
                m_await_init = 1'b0;
                m_active = 1'b1;
            end
        end else begin
            if (g) begin
                m_hcons = wrapm(m_hcons + 1, MH);
                m_dcons = wrapm(m_dcons + dreq, MD);
            end
            if (fc_upd_valid === 1'b1) begin
                if (!m_hinf) m_hlim = wrapm(int'(fc_hdr) << m_shift(int'(fc_hdr_scale)), MH);
                if (!m_dinf) m_dlim = wrapm(int'(fc_data) << m_shift(int'(fc_data_scale)), MD);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s.%s observed=%0h expected=%0h", phase, tag, obs, exp);
        end
    endtask

    // One clock: compare outputs against the model, then advance both
    task automatic cycle();
        bit g;
        int eh;
        int ed;
        #1;
        g  = m_grant();
        eh = m_hinf ? MH - 1 : wrapm(m_hlim - m_hcons, MH);
        ed = m_dinf ? MD - 1 : wrapm(m_dlim - m_dcons, MD);
        dut_grant_seen = req_grant;
        chk("grant", 32'(req_grant), 32'(g));
        chk("fc_active", 32'(fc_active), 32'(m_active));
        chk("hdr_avail", 32'(hdr_creds_avail), 32'(eh));
        chk("data_avail", 32'(data_creds_avail), 32'(ed));
        @(posedge clk);
        model_edge(g);
        #1;
    endtask

    task automatic link_restart();
        dl_up = 1'b0; cycle();
        dl_up = 1'b1; cycle();
    endtask

    task automatic do_init(input int h, input int d, input int hs, input int ds);
        fc_init_valid = 1'b1;
        fc_hdr = 8'(h); fc_data = 12'(d);
        fc_hdr_scale = 2'(hs); fc_data_scale = 2'(ds);
        cycle();
        fc_init_valid = 1'b0;
    endtask

    // Program a data limit value; large multiples of 16 use scale 11
    task automatic upd_data(input int x);
        fc_upd_valid = 1'b1;
        fc_hdr = 8'd1; fc_hdr_scale = 2'd0;
        if (x < 4096) begin
            fc_data = 12'(x); fc_data_scale = 2'd0;
        end else begin
            fc_data = 12'(x >> 4); fc_data_scale = 2'd3;
        end
        cycle();
        fc_upd_valid = 1'b0;
    endtask

    task automatic do_req(input int len);
        req_valid = 1'b1; req_has_data = 1'b1; req_len_dw = PAYLOAD_LENGTH'(len);
        cycle();
        req_valid = 1'b0;
    endtask

    initial begin
        int cons;
        arst_n = 1'b0; dl_up = 1'b0;
        fc_init_valid = 1'b0; fc_upd_valid = 1'b0;
        fc_hdr = '0; fc_data = '0; fc_hdr_scale = '0; fc_data_scale = '0;
        req_valid = 1'b0; req_has_data = 1'b0; req_len_dw = '0;
        dut_grant_seen = 1'b0;
        model_clear();

        // Reset values
        #1;
        chk("rst_grant", 32'(req_grant), 32'd0);
        chk("rst_active", 32'(fc_active), 32'd0);
        chk("rst_hdr_avail", 32'(hdr_creds_avail), 32'd0);
        chk("rst_data_avail", 32'(data_creds_avail), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        arst_n = 1'b1;

        // Basic grant/deny and UpdateFC release
        phase = "basic";
        dl_up = 1'b1; cycle();
        do_init(4, 16, 1, 1);
        chk("active_after_init", 32'(fc_active), 32'd1);
        chk("data_avail_init", 32'(data_creds_avail), 32'd16);
        do_req(64);
        chk("grant_64dw", 32'(dut_grant_seen), 32'd1);
        do_req(1);
        chk("deny_1dw", 32'(dut_grant_seen), 32'd0);
        fc_upd_valid = 1'b1; fc_hdr = 8'd4; fc_data = 12'd17;
        cycle();
        fc_upd_valid = 1'b0;
        do_req(1);
        chk("grant_after_upd", 32'(dut_grant_seen), 32'd1);

        // Infinite credits: 1024 DW every cycle, updates ignored
        phase = "infinite";
        link_restart();
        do_init(0, 0, 0, 0);
        for (int i = 0; i < 1000; i++) begin
            req_valid = 1'b1; req_has_data = 1'b1; req_len_dw = '0;
            fc_upd_valid = ($urandom_range(0, 7) == 0);
            fc_hdr = 8'($urandom_range(1, 3)); fc_data = 12'($urandom_range(1, 3));
            cycle();
            chk("inf_grant", 32'(dut_grant_seen), 32'd1);
        end
        req_valid = 1'b0; fc_upd_valid = 1'b0;
        chk("inf_hdr_ones", 32'(hdr_creds_avail), 32'(MH - 1));
        chk("inf_data_ones", 32'(data_creds_avail), 32'(MD - 1));

        // Scaled data limit
        phase = "scale";
        link_restart();
        do_init(10, 2, 0, 3);
        do_req(128);
        chk("grant_128dw", 32'(dut_grant_seen), 32'(SCALED));
        do_req(132);
        chk("deny_132dw", 32'(dut_grant_seen), 32'd0);

        // Drive the data counter around the wrap point
        phase = "wrap";
        link_restart();
        do_init(0, 256, 0, 0);
        cons = 0;
        for (int k = 0; k < MD / 256 - 1; k++) begin
            do_req(0);
            cons = cons + 256;
            upd_data(wrapm(cons + 256, MD));
        end
        do_req(1016);
        chk("grant_to_edge", 32'(dut_grant_seen), 32'd1);
        upd_data(2);
        do_req(16);
        chk("grant_wrapped", 32'(dut_grant_seen), 32'd1);
        chk("wrapped_avail0", 32'(data_creds_avail), 32'd0);

        // Grant and UpdateFC on the same edge decide on the old limit
        phase = "same_edge";
        req_valid = 1'b1; req_has_data = 1'b1; req_len_dw = 10'd16;
        upd_data(20);
        req_valid = 1'b0;
        chk("deny_old_limit", 32'(dut_grant_seen), 32'd0);
        chk("avail_new_limit", 32'(data_creds_avail), 32'd18);
        req_valid = 1'b1; req_has_data = 1'b1; req_len_dw = 10'd16;
        upd_data(6);
        req_valid = 1'b0;
        chk("grant_old_limit", 32'(dut_grant_seen), 32'd1);
        chk("avail_both_applied", 32'(data_creds_avail), 32'd0);

        // Link drop mid-stream, then re-up needs a fresh InitFC
        phase = "link_drop";
        req_valid = 1'b1; req_has_data = 1'b1; req_len_dw = 10'd4;
        dl_up = 1'b0;
        cycle();
        cycle();
        chk("down_grant", 32'(dut_grant_seen), 32'd0);
        chk("down_active", 32'(fc_active), 32'd0);
        chk("down_data_avail", 32'(data_creds_avail), 32'd0);
        dl_up = 1'b1;
        cycle();
        cycle();
        chk("await_init_grant", 32'(dut_grant_seen), 32'd0);
        fc_init_valid = 1'b1; fc_hdr = 8'd5; fc_data = 12'd5;
        fc_hdr_scale = 2'd0; fc_data_scale = 2'd0;
        cycle();
        fc_init_valid = 1'b0;
        chk("init_cycle_grant", 32'(dut_grant_seen), 32'd0);
        cycle();
        chk("reinit_grant", 32'(dut_grant_seen), 32'd1);
        req_valid = 1'b0;

        // Randomized traffic against the model
        phase = "random";
        for (int i = 0; i < 1500; i++) begin
            dl_up         = ($urandom_range(0, 99) != 0);
            fc_init_valid = ($urandom_range(0, 7) == 0);
            fc_upd_valid  = ($urandom_range(0, 5) == 0);
            fc_hdr        = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 40));
            fc_data       = ($urandom_range(0, 15) == 0) ? 12'd0 : 12'($urandom_range(0, 4095));
            fc_hdr_scale  = 2'($urandom_range(0, 3));
            fc_data_scale = 2'($urandom_range(0, 3));
            req_valid     = 1'($urandom_range(0, 1));
            req_has_data  = 1'($urandom_range(0, 1));
            req_len_dw    = PAYLOAD_LENGTH'($urandom_range(0, 1023));
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
